// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the rv32i pipeline stall controller.
//   stall_state_t   : controller state (run, load-use bubble, memory wait)
//   PerfW           : width of the performance counters
//   lu_mask_active  : true while a load-use flag must be ignored
package pipeline_stall_ctrl_pkg;

    localparam int unsigned PerfW = 32;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLuBubble = 2'd1,
        StMemWait  = 2'd2
    } stall_state_t;

    // The load-use flag stays high while the bubble drains; it must not re-trigger.
    function automatic logic lu_mask_active(input stall_state_t st, input logic lu_pend);
        return (st == StLuBubble) || ((st == StMemWait) && lu_pend);
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_perf_counter.sv
// Free-running wrap-around event counter for the stall controller.
// Present only when STALL_PERF_CNT_EN is defined.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   en    : count this cycle
//   count : current count, wraps at 2**WIDTH
`ifdef STALL_PERF_CNT_EN
module pipeline_stall_ctrl_perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller for the 5-stage rv32i core.
// Turns cache handshakes, the load-use flag and the EX redirect into
// register enables, bubbles, flushes and cache request masks.
// Priority per cycle: freeze (cache wait) > load-use > branch redirect.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   load_use                 : load-use hazard from forwarding unit
//   br_taken                 : EX-stage redirect
//   imem_read / imem_resp    : fetch request / icache response
//   dmem_req / dmem_resp     : MEM-stage request / dcache response
//   load_*                   : PC and pipeline register enables
//   flush_if_id              : clear IF/ID to NOP
//   bubble_id_ex/ex_mem      : clear control word of ID/EX / EX/MEM
//   imem_mask / dmem_mask    : suppress a request already served during a freeze
//   err_timeout              : sticky, set after WAIT_TIMEOUT frozen cycles
//   perf_stall_cycles/bubbles: event counters
//
// Build option: STALL_PERF_CNT_EN adds the performance counters; when it is
// undefined both perf outputs are constant zero.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 1023,
    parameter int unsigned CNT_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic             imem_mask,
    output logic             dmem_mask,
    output logic             err_timeout,
    output logic [PerfW-1:0] perf_stall_cycles,
    output logic [PerfW-1:0] perf_bubbles
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(WAIT_TIMEOUT);

    stall_state_t     state_q, state_d;
    logic             lu_pend_q, lu_pend_d;
    logic             imem_done_q, imem_done_d;
    logic             dmem_done_q, dmem_done_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic             err_q, err_d;

    logic imem_pend, dmem_pend, freeze;
    logic lu_masked, lu_take;

    assign imem_pend = imem_read & ~imem_resp & ~imem_done_q;
    assign dmem_pend = dmem_req & ~dmem_resp & ~dmem_done_q;
    assign freeze    = imem_pend | dmem_pend;

    assign lu_masked = lu_mask_active(state_q, lu_pend_q);
    assign lu_take   = ~freeze & load_use & ~lu_masked;

    assign imem_mask   = imem_done_q;
    assign dmem_mask   = dmem_done_q;
    assign err_timeout = err_q;

    // Register enables, bubbles and flush.
    always_comb begin
        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        flush_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        if (freeze) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (lu_take) begin
            // Branch operands are not valid yet, so a redirect is ignored here.
            load_pc       = 1'b0;
            load_if_id    = 1'b0;
            load_id_ex    = 1'b0;
            bubble_ex_mem = 1'b1;
        end else if (br_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    // State, done flags and freeze counter.
    always_comb begin
        state_d      = StRun;
        lu_pend_d    = 1'b0;
        imem_done_d  = 1'b0;
        dmem_done_d  = 1'b0;
        freeze_cnt_d = '0;
        err_d        = err_q;
        if (freeze) begin
            state_d      = StMemWait;
            // Remember an undrained load-use bubble across the wait.
            lu_pend_d    = lu_masked;
            imem_done_d  = imem_done_q | imem_resp;
            dmem_done_d  = dmem_done_q | dmem_resp;
            freeze_cnt_d = (freeze_cnt_q == TimeoutVal) ? freeze_cnt_q
                                                        : freeze_cnt_q + CNT_W'(1);
        end else if (lu_take) begin
            state_d = StLuBubble;
        end else if ((state_q == StMemWait) && lu_pend_q) begin
            state_d = StLuBubble;
        end
        if (freeze_cnt_d == TimeoutVal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            lu_pend_q    <= 1'b0;
            imem_done_q  <= 1'b0;
            dmem_done_q  <= 1'b0;
            freeze_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lu_pend_q    <= lu_pend_d;
            imem_done_q  <= imem_done_d;
            dmem_done_q  <= dmem_done_d;
            freeze_cnt_q <= freeze_cnt_d;
            err_q        <= err_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic stall_evt, bubble_evt;

    assign stall_evt  = freeze | lu_take;
    assign bubble_evt = bubble_ex_mem | bubble_id_ex;

    pipeline_stall_ctrl_perf_counter #(
        .WIDTH (PerfW)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_evt),
        .count (perf_stall_cycles)
    );

    pipeline_stall_ctrl_perf_counter #(
        .WIDTH (PerfW)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bubble_evt),
        .count (perf_bubbles)
    );
`else
    assign perf_stall_cycles = '0;
    assign perf_bubbles      = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: the driver applies one input
// vector per cycle and queues the hand-computed output word; a monitor on the
// falling edge pops and compares.
// Output word: {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//               flush_if_id, bubble_id_ex, bubble_ex_mem, imem_mask, dmem_mask, err_timeout}
// Input word:  {load_use, br_taken, imem_read, imem_resp, dmem_req, dmem_resp}
module tb_pipeline_stall_ctrl;

    localparam logic [10:0] RUNV = 11'b11111_000_00_0;
    localparam logic [10:0] FRZ  = 11'b00000_000_00_0;
    localparam logic [10:0] LUV  = 11'b00011_001_00_0;
    localparam logic [10:0] BRV  = 11'b11111_110_00_0;
    localparam logic [10:0] DM   = 11'b00000_000_01_0;
    localparam logic [10:0] ERR  = 11'b00000_000_00_1;

    localparam logic [5:0] I_LU    = 6'b100000;
    localparam logic [5:0] I_BR    = 6'b010000;
    localparam logic [5:0] I_IR    = 6'b001000;
    localparam logic [5:0] I_IRESP = 6'b000100;
    localparam logic [5:0] I_DR    = 6'b000010;
    localparam logic [5:0] I_DRESP = 6'b000001;
    localparam logic [5:0] I_NONE  = 6'b000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use, br_taken, imem_read, imem_resp, dmem_req, dmem_resp;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, bubble_id_ex, bubble_ex_mem, imem_mask, dmem_mask;
    logic        err_timeout;
    logic [31:0] perf_stall_cycles, perf_bubbles;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [10:0] exp_q[$];
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .load_use          (load_use),
        .br_taken          (br_taken),
        .imem_read         (imem_read),
        .imem_resp         (imem_resp),
        .dmem_req          (dmem_req),
        .dmem_resp         (dmem_resp),
        .load_pc           (load_pc),
        .load_if_id        (load_if_id),
        .load_id_ex        (load_id_ex),
        .load_ex_mem       (load_ex_mem),
        .load_mem_wb       (load_mem_wb),
        .flush_if_id       (flush_if_id),
        .bubble_id_ex      (bubble_id_ex),
        .bubble_ex_mem     (bubble_ex_mem),
        .imem_mask         (imem_mask),
        .dmem_mask         (dmem_mask),
        .err_timeout       (err_timeout),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubbles      (perf_bubbles)
    );

    logic [10:0] act;
    assign act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  flush_if_id, bubble_id_ex, bubble_ex_mem, imem_mask, dmem_mask, err_timeout};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    // Monitor: outputs are valid every cycle once a vector is queued.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            check("outputs", {21'd0, act}, {21'd0, e});
        end
    end

    task automatic step(input logic [5:0] in, input logic [10:0] e);
        @(posedge clk);
        #1;
        {load_use, br_taken, imem_read, imem_resp, dmem_req, dmem_resp} = in;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        {load_use, br_taken, imem_read, imem_resp, dmem_req, dmem_resp} = I_NONE;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] exp_stall, exp_bub;

    initial begin
        rst = 1'b1;
        {load_use, br_taken, imem_read, imem_resp, dmem_req, dmem_resp} = I_NONE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        step(I_NONE, RUNV);
        @(negedge clk);
        check("perf_stall_rst", perf_stall_cycles, 32'd0);
        check("perf_bub_rst", perf_bubbles, 32'd0);

        // Load-use bubble, then the held flag is masked for one cycle.
        step(I_LU, LUV);
        step(I_LU, RUNV);
        step(I_NONE, RUNV);

        // Load-use wins over branch; branch honoured in the bubble cycle.
        step(I_LU | I_BR, LUV);
        step(I_BR, BRV);
        step(I_NONE, RUNV);

        // Fetch miss: 5 frozen cycles, released in the response cycle.
        for (int i = 0; i < 5; i++) step(I_IR, FRZ);
        step(I_IR | I_IRESP, RUNV);
        step(I_NONE, RUNV);

        // Branch held across a freeze acts on the first unfrozen cycle.
        step(I_IR | I_BR, FRZ);
        step(I_IR | I_BR, FRZ);
        step(I_IR | I_IRESP | I_BR, BRV);
        step(I_NONE, RUNV);

        // Load-use held across a freeze acts on the first unfrozen cycle.
        step(I_IR | I_LU, FRZ);
        step(I_IR | I_IRESP | I_LU, LUV);
        step(I_LU, RUNV);
        step(I_NONE, RUNV);

        // Both ports pending: dcache answers at cycle 2, icache at cycle 6.
        step(I_IR | I_DR, FRZ);
        step(I_IR | I_DR, FRZ);
        step(I_IR | I_DR | I_DRESP, FRZ);
        for (int i = 0; i < 3; i++) step(I_IR | I_DR, FRZ | DM);
        step(I_IR | I_DR | I_IRESP, RUNV | DM);
        step(I_NONE, RUNV);

        // Reset mid-freeze drops the served-request mask.
        step(I_IR | I_DR, FRZ);
        step(I_IR | I_DR | I_DRESP, FRZ);
        do_reset();
        step(I_DR, FRZ);
        step(I_DR | I_DRESP, RUNV);
        step(I_NONE, RUNV);

        // Performance counters: 3 frozen + 1 load-use, 2 bubble cycles.
        do_reset();
        for (int i = 0; i < 3; i++) step(I_IR, FRZ);
        step(I_IR | I_IRESP, RUNV);
        step(I_LU, LUV);
        step(I_NONE, RUNV);
        step(I_BR, BRV);
        step(I_NONE, RUNV);
        @(negedge clk);
`ifdef STALL_PERF_CNT_EN
        exp_stall = 32'd4;
        exp_bub   = 32'd2;
`else
        exp_stall = 32'd0;
        exp_bub   = 32'd0;
`endif
        check("perf_stall_cycles", perf_stall_cycles, exp_stall);
        check("perf_bubbles", perf_bubbles, exp_bub);

        // Timeout: error appears exactly after 1023 frozen cycles and is sticky.
        do_reset();
        for (int i = 0; i < 1023; i++) step(I_IR, FRZ);
        step(I_IR | I_IRESP, RUNV | ERR);
        step(I_NONE, RUNV | ERR);
        do_reset();
        step(I_NONE, RUNV);

        // Drain the scoreboard with a bound.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
